reg_file_bypass: RTL and testbench

REG_FILE_BYPASS -- requirements
Module: reg_file_bypass

---
 rtl/reg_file_bypass.sv | 127 ++++++++++++
 tb/tb_reg_file_bypass.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_bypass.sv
// reg_file_bypass
//   Register file with byte-masked write, two combinational read ports,
//   optional same-cycle write-to-read forwarding, and a busy-bit
//   scoreboard that tracks registers with an issued but not yet written
//   producer.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   RegWrite              write enable
//   Rd_Addr/Data/ByteEn   write address, data and per-byte mask
//   Rs_Addr, Rt_Addr      read addresses
//   Rs_Data, Rt_Data      combinational read data (forwarded when enabled)
//   Issue_Valid/Addr      producer issued for Issue_Addr this cycle
//   Rs_Busy, Rt_Busy      addressed register still has a pending producer
//   Busy_Cnt              registered number of busy registers
module reg_file_bypass #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RegWrite,
  input  logic [ADDR_W-1:0]   Rd_Addr,
  input  logic [DATA_W-1:0]   Rd_Data,
  input  logic [DATA_W/8-1:0] Rd_ByteEn,
  input  logic [ADDR_W-1:0]   Rs_Addr,
  input  logic [ADDR_W-1:0]   Rt_Addr,
  output logic [DATA_W-1:0]   Rs_Data,
  output logic [DATA_W-1:0]   Rt_Data,
  input  logic                Issue_Valid,
  input  logic [ADDR_W-1:0]   Issue_Addr,
  output logic                Rs_Busy,
  output logic                Rt_Busy,
  output logic [ADDR_W:0]     Busy_Cnt
);

  localparam int NB    = DATA_W / 8;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;

  logic wr_en;
  logic issue_en;
  logic cnt_inc, cnt_dec;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign wr_en    = RegWrite    && !(ZERO_REG && (Rd_Addr == '0));
  assign issue_en = Issue_Valid && !(ZERO_REG && (Issue_Addr == '0));

  // ---------------------------------------------------------------- storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (Rd_ByteEn[b]) regs_q[Rd_Addr][8*b +: 8] <= Rd_Data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- reads
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] stored,
    input logic [DATA_W-1:0] wdata,
    input logic [NB-1:0]     be
  );
    logic [DATA_W-1:0] v;
    v = stored;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) v[8*b +: 8] = wdata[8*b +: 8];
    end
    return v;
  endfunction

  logic [DATA_W-1:0] rs_stored, rt_stored;
  logic              rs_fwd, rt_fwd;

  assign rs_stored = (ZERO_REG && (Rs_Addr == '0)) ? '0 : regs_q[Rs_Addr];
  assign rt_stored = (ZERO_REG && (Rt_Addr == '0)) ? '0 : regs_q[Rt_Addr];

  // Forwarding is gated by rst_n so a write held during reset cannot leak
  // onto the read ports.
  assign rs_fwd = BYPASS && rst_n && wr_en && (Rd_Addr == Rs_Addr);
  assign rt_fwd = BYPASS && rst_n && wr_en && (Rd_Addr == Rt_Addr);

  assign Rs_Data = rs_fwd ? merge_bytes(rs_stored, Rd_Data, Rd_ByteEn) : rs_stored;
  assign Rt_Data = rt_fwd ? merge_bytes(rt_stored, Rd_Data, Rd_ByteEn) : rt_stored;

  // A register being written this cycle is no longer waiting once its value
  // is forwarded.
  assign Rs_Busy = busy_q[Rs_Addr] && !rs_fwd;
  assign Rt_Busy = busy_q[Rt_Addr] && !rt_fwd;

  // ---------------------------------------------------------------- scoreboard
  // Count is kept incrementally: a set only counts on a 0->1 transition, a
  // clear only on 1->0, and a clear overridden by a same-address issue
  // leaves the bit (and the count) untouched.
  assign cnt_inc = issue_en && !busy_q[Issue_Addr];
  assign cnt_dec = RegWrite && busy_q[Rd_Addr] &&
                   !(issue_en && (Issue_Addr == Rd_Addr));

  always_comb begin
    busy_d = busy_q;
    if (RegWrite) busy_d[Rd_Addr]    = 1'b0;
    if (issue_en) busy_d[Issue_Addr] = 1'b1;
  end

  assign busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign Busy_Cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_bypass.sv
module tb_reg_file_bypass;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  Rd_Addr;
  logic [31:0] Rd_Data;
  logic [3:0]  Rd_ByteEn;
  logic [4:0]  Rs_Addr, Rt_Addr;
  logic [31:0] Rs_Data, Rt_Data;
  logic        Issue_Valid;
  logic [4:0]  Issue_Addr;
  logic        Rs_Busy, Rt_Busy;
  logic [5:0]  Busy_Cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_bypass dut (
    .clk(clk), .rst_n(rst_n),
    .RegWrite(RegWrite), .Rd_Addr(Rd_Addr), .Rd_Data(Rd_Data), .Rd_ByteEn(Rd_ByteEn),
    .Rs_Addr(Rs_Addr), .Rt_Addr(Rt_Addr), .Rs_Data(Rs_Data), .Rt_Data(Rt_Data),
    .Issue_Valid(Issue_Valid), .Issue_Addr(Issue_Addr),
    .Rs_Busy(Rs_Busy), .Rt_Busy(Rt_Busy), .Busy_Cnt(Busy_Cnt)
  );

  // Reference model: architectural register contents and the set of
  // registers waiting on a producer.
  logic [31:0] m_mem  [32];
  bit          m_busy [32];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  be);
    logic [31:0] v;
    v = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = new_v[8*b +: 8];
    return v;
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0 || !rst_n) return 32'h0;
    if (RegWrite && Rd_Addr == a) return merge(m_mem[a], Rd_Data, Rd_ByteEn);
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (!rst_n) return 1'b0;
    return m_busy[a] && !(RegWrite && Rd_Addr == a);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_in(input logic we, input logic [4:0] rd, input logic [31:0] d,
                        input logic [3:0] be, input logic [4:0] rs, input logic [4:0] rt,
                        input logic iv, input logic [4:0] ia);
    RegWrite = we; Rd_Addr = rd; Rd_Data = d; Rd_ByteEn = be;
    Rs_Addr = rs; Rt_Addr = rt; Issue_Valid = iv; Issue_Addr = ia;
  endtask

  task automatic comb_chk(input string tag);
    chk({tag, ".rs_data"}, 64'(Rs_Data), 64'(exp_data(Rs_Addr)));
    chk({tag, ".rt_data"}, 64'(Rt_Data), 64'(exp_data(Rt_Addr)));
    chk({tag, ".rs_busy"}, 64'(Rs_Busy), 64'(exp_busy(Rs_Addr)));
    chk({tag, ".rt_busy"}, 64'(Rt_Busy), 64'(exp_busy(Rt_Addr)));
  endtask

  // Advance one rising edge, apply the rules to the model, then check the
  // registered count just after the edge.
  task automatic edge_step(input string tag);
    @(posedge clk);
    if (rst_n) begin
      if (RegWrite && Rd_Addr != 0) m_mem[Rd_Addr] = merge(m_mem[Rd_Addr], Rd_Data, Rd_ByteEn);
      if (RegWrite) m_busy[Rd_Addr] = 1'b0;
      if (Issue_Valid && Issue_Addr != 0) m_busy[Issue_Addr] = 1'b1;
    end
    #1;
    chk({tag, ".busy_cnt"}, 64'(Busy_Cnt), 64'(m_count()));
  endtask

  task automatic step(input string tag);
    @(negedge clk);
    comb_chk(tag);
    edge_step(tag);
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    set_in(1'b1, 5'd5, 32'hFFFF_FFFF, 4'hF, 5'd5, 5'd6, 1'b1, 5'd5);
    #3;
    chk("reset.busy_cnt", 64'(Busy_Cnt), 64'd0);
    chk("reset.rs_data", 64'(Rs_Data), 64'd0);
    chk("reset.rs_busy", 64'(Rs_Busy), 64'd0);
    #9 rst_n = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    @(posedge clk); #1;
    chk("reset.post_cnt", 64'(Busy_Cnt), 64'd0);

    // Full-word write then read back.
    set_in(1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF, 5'd1, 5'd2, 1'b0, 5'd0);
    step("w5");
    set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk("r5", 64'(Rs_Data), 64'hDEAD_BEEF);
    comb_chk("r5");
    edge_step("r5");

    // Byte-masked write with same-cycle forwarding.
    set_in(1'b1, 5'd7, 32'h1122_3344, 4'hF, 5'd0, 5'd0, 1'b0, 5'd0);
    step("w7");
    set_in(1'b1, 5'd7, 32'hAABB_CCDD, 4'b0101, 5'd7, 5'd5, 1'b0, 5'd0);
    @(negedge clk);
    chk("bypass7", 64'(Rs_Data), 64'h11BB_33DD);
    comb_chk("bypass7");
    edge_step("bypass7");
    set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd7, 1'b0, 5'd0);
    @(negedge clk);
    chk("stored7", 64'(Rt_Data), 64'h11BB_33DD);
    edge_step("stored7");

    // Register zero: write and issue are both discarded.
    set_in(1'b1, 5'd0, 32'hFFFF_FFFF, 4'hF, 5'd0, 5'd0, 1'b1, 5'd0);
    @(negedge clk);
    chk("r0.rt_data", 64'(Rt_Data), 64'd0);
    chk("r0.rt_busy", 64'(Rt_Busy), 64'd0);
    edge_step("r0");
    chk("r0.cnt", 64'(Busy_Cnt), 64'd0);
    set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    @(negedge clk);
    chk("r0.rt_busy_after", 64'(Rt_Busy), 64'd0);
    chk("r0.rt_data_after", 64'(Rt_Data), 64'd0);
    edge_step("r0b");

    // Scoreboard: set, overlapping set/clear, clear with forwarding.
    set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd9, 1'b1, 5'd3);
    step("iss3");
    set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd9, 1'b1, 5'd9);
    step("iss9");
    chk("iss9.cnt", 64'(Busy_Cnt), 64'd2);
    set_in(1'b1, 5'd3, 32'h0000_0333, 4'hF, 5'd1, 5'd9, 1'b1, 5'd3);
    step("setclr3");
    chk("setclr3.cnt", 64'(Busy_Cnt), 64'd2);
    set_in(1'b1, 5'd9, 32'h0000_0999, 4'hF, 5'd9, 5'd3, 1'b1, 5'd3);
    @(negedge clk);
    chk("clr9.rs_busy", 64'(Rs_Busy), 64'd0);
    chk("waw3.rt_busy", 64'(Rt_Busy), 64'd1);
    comb_chk("clr9");
    edge_step("clr9");
    chk("clr9.cnt", 64'(Busy_Cnt), 64'd1);

    // Mid-operation reset.
    for (int i = 10; i < 14; i++) begin
      set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'(i), 5'd3, 1'b1, 5'(i));
      step("iss4");
    end
    chk("iss4.cnt", 64'(Busy_Cnt), 64'd5);
    set_in(1'b1, 5'd3, 32'h1234_5678, 4'hF, 5'd3, 5'd7, 1'b1, 5'd14);
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    chk("midrst.cnt", 64'(Busy_Cnt), 64'd0);
    chk("midrst.rs_data", 64'(Rs_Data), 64'd0);
    chk("midrst.rt_data", 64'(Rt_Data), 64'd0);
    chk("midrst.rs_busy", 64'(Rs_Busy), 64'd0);
    chk("midrst.rt_busy", 64'(Rt_Busy), 64'd0);
    #1 rst_n = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 4'h0, 5'd2, 5'd7, 1'b1, 5'd2);
    step("iss2");
    chk("iss2.cnt", 64'(Busy_Cnt), 64'd1);

    // Randomised traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic        we, iv;
      logic [4:0]  rd, rs, rt, ia;
      we = 1'($urandom_range(0, 1));
      iv = 1'($urandom_range(0, 3) != 0);
      rd = 5'($urandom_range(0, 31));
      ia = 5'($urandom_range(0, 31));
      rs = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rt = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      set_in(we, rd, $urandom, 4'($urandom_range(0, 15)), rs, rt, iv, ia);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
